// File: rtl/alu_pkg.sv
// Shared types, function codes and latency helper for the ALU function dispatcher.
package alu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } disp_state_t;

   localparam logic [1:0] ARITH = 2'd0;
   localparam logic [1:0] LOGIC = 2'd1;
   localparam logic [1:0] CMP   = 2'd2;
   localparam logic [1:0] SHIFT = 2'd3;

   // A zero latency field would never complete, so it is treated as one cycle.
   function automatic logic [31:0] unit_lat(input logic [63:0] latVec,
                                            input int unsigned latW,
                                            input int unsigned fun);
      logic [63:0] field;
      field = (latVec >> (fun * latW)) & ((64'd1 << latW) - 64'd1);
      unit_lat = (field == 64'd0) ? 32'd1 : field[31:0];
   endfunction

endpackage

// File: rtl/alu_dispatch_stats.sv
// Per-unit saturating issue counters with a combinational read port.
module alu_dispatch_stats
   import alu_pkg::*;
#(
   parameter int SEL_W  = 2,
   parameter int STAT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              issue_i,
   input  logic [SEL_W-1:0]  issueFun_i,
   input  logic [SEL_W-1:0]  statSel_i,
   output logic [STAT_W-1:0] statCount_o
);

   localparam int NUM_UNITS = 2**SEL_W;

   logic [STAT_W-1:0] count_q [NUM_UNITS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            count_q[i] <= '0;
         end
      end else if (issue_i && (count_q[issueFun_i] != {STAT_W{1'b1}})) begin
         count_q[issueFun_i] <= count_q[issueFun_i] + STAT_W'(1);
      end
   end

   assign statCount_o = count_q[statSel_i];

endmodule

// File: rtl/alu_fun_dispatch.sv
// Registered ALU function dispatcher: one-hot unit enable held for a per-unit latency.
// Optional issue statistics are built when ALU_DISPATCH_STATS_EN is defined.
module alu_fun_dispatch
   import alu_pkg::*;
#(
   parameter int SEL_W = 2,
   parameter int LAT_W = 3,
   parameter logic [(2**SEL_W)*LAT_W-1:0] UNIT_LAT = 12'h849
`ifdef ALU_DISPATCH_STATS_EN
   ,
   parameter int STAT_W = 16
`endif
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  In_Valid,
   output logic                  In_Ready,
   input  logic [SEL_W-1:0]      ALU_FUN,
   input  logic                  Abort,
   output logic [2**SEL_W-1:0]   Unit_Enable,
   output logic                  Busy,
   output logic                  Done,
   output logic [SEL_W-1:0]      Done_Fun
`ifdef ALU_DISPATCH_STATS_EN
   ,
   input  logic [SEL_W-1:0]      Stat_Sel,
   output logic [STAT_W-1:0]     Stat_Count
`endif
);

   localparam int NUM_UNITS = 2**SEL_W;

   disp_state_t            state_q, state_d;
   logic [LAT_W-1:0]       count_q, count_d;
   logic [NUM_UNITS-1:0]   enable_q, enable_d;
   logic [SEL_W-1:0]       fun_q, fun_d;

   logic                   lastCycle;
   logic                   accept;
   logic [LAT_W-1:0]       loadLat;
   logic [NUM_UNITS-1:0]   loadEnable;

   assign lastCycle  = (state_q == BUSY) && (count_q == LAT_W'(1));
   assign In_Ready   = (state_q == IDLE) || (lastCycle && !Abort);
   assign accept     = In_Valid && In_Ready;
   assign loadLat    = LAT_W'(unit_lat(64'(UNIT_LAT), LAT_W, 32'(ALU_FUN)));
   assign loadEnable = NUM_UNITS'(1) << ALU_FUN;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         count_q  <= '0;
         enable_q <= '0;
         fun_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         enable_q <= enable_d;
         fun_q    <= fun_d;
      end
   end

   // An accept on the final enable cycle reloads directly, giving gap-free issue.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      enable_d = enable_q;
      fun_d    = fun_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = BUSY;
               count_d  = loadLat;
               enable_d = loadEnable;
               fun_d    = ALU_FUN;
            end
         end
         BUSY: begin
            if (Abort) begin
               state_d  = IDLE;
               count_d  = '0;
               enable_d = '0;
            end else if (lastCycle) begin
               if (accept) begin
                  count_d  = loadLat;
                  enable_d = loadEnable;
                  fun_d    = ALU_FUN;
               end else begin
                  state_d  = IDLE;
                  count_d  = '0;
                  enable_d = '0;
               end
            end else begin
               count_d = count_q - LAT_W'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            count_d  = '0;
            enable_d = '0;
         end
      endcase
   end

   assign Unit_Enable = enable_q;
   assign Busy        = (state_q == BUSY);
   assign Done        = lastCycle && !Abort;
   assign Done_Fun    = fun_q;

`ifdef ALU_DISPATCH_STATS_EN
   alu_dispatch_stats #(
      .SEL_W (SEL_W),
      .STAT_W(STAT_W)
   ) u_stats (
      .clk_i      (CLK),
      .rst_i      (RST),
      .issue_i    (accept),
      .issueFun_i (ALU_FUN),
      .statSel_i  (Stat_Sel),
      .statCount_o(Stat_Count)
   );
`endif

endmodule
